// File: rtl/ysyx_23060203_ifu.sv
// Instruction fetch unit: takes PCs from the PC generator, fetches each
// instruction over an AXI4-Lite read channel (AR and R only) and hands
// {pc, inst, err} to the decoder with a valid/ready handshake.
// At most one bus transaction is outstanding. A redirect flush kills the
// current fetch; any address already issued is still completed on the bus
// and its response is drained and dropped.
//
// Optional build macro: YSYX_23060203_IFU_ALIGN_CHECK_EN
//   defined   - an accepted PC with in_pc[1:0] != 0 never reaches the bus;
//               it is reported directly as a bus error with inst = 0.
//   undefined - no check; the full PC is passed to araddr unchanged.
module ysyx_23060203_ifu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,

    // PC generator side
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic              flush,

    // AXI4-Lite read address channel
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,

    // AXI4-Lite read data channel
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,

    // Decoder side
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_inst,
    output logic              out_err
);

    typedef enum logic [2:0] {
        IDLE,   // waiting for a PC
        ADDR,   // address offered on AR, waiting for arready
        DATA,   // waiting for the read response
        DONE,   // instruction presented to the decoder
        DRAIN   // flushed fetch: swallow the pending response
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   pc_q;
    logic [DATA_W-1:0]   inst_q;
    logic                err_q;
    logic                flushed_q;

    logic                accept;
    logic                misaligned;

`ifdef YSYX_23060203_IFU_ALIGN_CHECK_EN
    assign misaligned = |in_pc[1:0];
`else
    assign misaligned = 1'b0;
`endif

    assign accept = in_valid & in_ready;

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = misaligned ? DONE : ADDR;
                end
            end
            ADDR: begin
                // The address is never withdrawn; a flush only decides
                // whether the response is kept or drained.
                if (arready) begin
                    state_d = (flush | flushed_q) ? DRAIN : DATA;
                end
            end
            DATA: begin
                if (flush) begin
                    state_d = rvalid ? IDLE : DRAIN;
                end else if (rvalid) begin
                    state_d = DONE;
                end
            end
            DRAIN: begin
                if (rvalid) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                // accept already excludes flush, so a flushed handshake is void.
                if (flush) begin
                    state_d = IDLE;
                end else if (out_ready) begin
                    if (accept) begin
                        state_d = misaligned ? DONE : ADDR;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from registered state
    always_comb begin
        // rstn gates in_ready so no PC is taken while the block is held in reset.
        in_ready  = rstn & ~flush &
                    ((state_q == IDLE) | ((state_q == DONE) & out_ready));
        arvalid   = (state_q == ADDR);
        rready    = (state_q == DATA) | (state_q == DRAIN);
        out_valid = (state_q == DONE);
    end

    assign araddr   = pc_q;
    assign out_pc   = pc_q;
    assign out_inst = inst_q;
    assign out_err  = err_q;

    // Fetch payload: PC on acceptance, instruction and error on the response
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q   <= '0;
            inst_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                pc_q <= in_pc;
                if (misaligned) begin
                    inst_q <= '0;
                    err_q  <= 1'b1;
                end
            end
            if ((state_q == DATA) && rvalid && !flush) begin
                inst_q <= rdata;
                err_q  <= (rresp != 2'b00);
            end
        end
    end

    // Remembers a flush seen while the address is still waiting for arready
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            flushed_q <= 1'b0;
        end else if (state_q == ADDR) begin
            flushed_q <= arready ? 1'b0 : (flushed_q | flush);
        end else begin
            flushed_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ysyx_23060203_ifu.sv
// Self-checking bench for ysyx_23060203_ifu (default build, alignment check
// disabled). The bench plays both the PC generator / decoder and the AXI
// slave. Inputs change just after the falling edge; outputs are checked
// 1 time unit later, well away from the rising edge.
module tb_ysyx_23060203_ifu;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rstn;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_pc;
    logic              flush;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_pc;
    logic [DATA_W-1:0] out_inst;
    logic              out_err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        int          ar_wait;   // cycles arready held low
        int          r_wait;    // cycles rvalid held low
        int          dn_wait;   // cycles out_ready held low
        logic [31:0] exp_inst;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    ysyx_23060203_ifu #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .flush     (flush),
        .araddr    (araddr),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rvalid    (rvalid),
        .rready    (rready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drive one fetch up to DONE and check it while held there for dn_wait
    // cycles. With skip_accept=1 the PC has already been accepted.
    task automatic fetch_to_done(input vec_t v, input bit skip_accept);
        flush   = 1'b0;
        arready = 1'b0;
        rvalid  = 1'b0;
        if (!skip_accept) begin
            out_ready = 1'b0;
            in_pc     = v.pc;
            in_valid  = 1'b1;
            #1 check("in_ready_idle", in_ready, 1);
            tick();
            in_valid = 1'b0;
        end
        for (int i = 0; i < v.ar_wait; i++) begin
            #1 check("arvalid_hold", arvalid, 1);
            check("araddr_hold", araddr, v.pc);
            tick();
        end
        arready = 1'b1;
        #1 check("arvalid", arvalid, 1);
        check("araddr", araddr, v.pc);
        check("out_valid_addr", out_valid, 0);
        tick();
        arready = 1'b0;
        for (int i = 0; i < v.r_wait; i++) begin
            #1 check("rready_wait", rready, 1);
            check("out_valid_wait", out_valid, 0);
            tick();
        end
        rvalid = 1'b1;
        rdata  = v.rdata;
        rresp  = v.rresp;
        #1 check("rready", rready, 1);
        tick();
        rvalid = 1'b0;
        rdata  = 32'h0;
        rresp  = 2'b00;
        for (int i = 0; i <= v.dn_wait; i++) begin
            #1 check("out_valid", out_valid, 1);
            check("out_pc", out_pc, v.pc);
            check("out_inst", out_inst, v.exp_inst);
            check("out_err", out_err, v.exp_err);
            check("rready_done", rready, 0);
            if (i < v.dn_wait) tick();
        end
    endtask

    // Complete the decoder handshake with no new PC, ending in IDLE
    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1 check("out_valid_after", out_valid, 0);
        check("arvalid_after", arvalid, 0);
        check("in_ready_after", in_ready, 1);
    endtask

    initial begin
        vec_t v;

        vecs[0] = '{32'h8000_0000, 32'h0000_0413, 2'b00, 0, 0, 0, 32'h0000_0413, 1'b0};
        vecs[1] = '{32'h8000_0004, 32'h0010_0093, 2'b00, 4, 3, 5, 32'h0010_0093, 1'b0};
        vecs[2] = '{32'h8000_0008, 32'h1234_5678, 2'b10, 0, 1, 0, 32'h1234_5678, 1'b1};
        vecs[3] = '{32'h8000_0003, 32'hcafe_f00d, 2'b00, 1, 0, 2, 32'hcafe_f00d, 1'b0};
        vecs[4] = '{32'hffff_fffc, 32'hffff_ffff, 2'b11, 2, 2, 1, 32'hffff_ffff, 1'b1};
        vecs[5] = '{32'h0000_0010, 32'h0000_0000, 2'b01, 0, 0, 0, 32'h0000_0000, 1'b1};

        // Reset with a PC offered
        rstn = 1'b0; in_valid = 1'b1; in_pc = 32'h8000_0000; flush = 1'b0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; out_ready = 1'b0;
        tick(); tick();
        #1 check("rst_arvalid", arvalid, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_rready", rready, 0);
        check("rst_out_pc", out_pc, 0);
        in_valid = 1'b0;
        rstn = 1'b1;
        tick();
        #1 check("post_rst_in_ready", in_ready, 1);
        check("post_rst_arvalid", arvalid, 0);

        // Table of straight fetches
        for (int k = 0; k < 6; k++) begin
            fetch_to_done(vecs[k], 1'b0);
            release_out();
            tick();
        end

        // Back-to-back: new PC accepted in the same cycle as the out handshake
        v = '{32'h8000_0000, 32'h0000_0413, 2'b00, 0, 0, 2, 32'h0000_0413, 1'b0};
        fetch_to_done(v, 1'b0);
        out_ready = 1'b1; in_valid = 1'b1; in_pc = 32'h8000_0004;
        #1 check("b2b_in_ready", in_ready, 1);
        tick();
        out_ready = 1'b0; in_valid = 1'b0;
        #1 check("b2b_out_valid", out_valid, 0);
        check("b2b_arvalid", arvalid, 1);
        check("b2b_araddr", araddr, 32'h8000_0004);
        v = '{32'h8000_0004, 32'h0000_0513, 2'b00, 1, 1, 0, 32'h0000_0513, 1'b0};
        fetch_to_done(v, 1'b1);
        release_out();

        // Flush while the address waits: AR held, response drained
        in_valid = 1'b1; in_pc = 32'h8000_0040;
        tick();
        in_valid = 1'b0; flush = 1'b1;
        #1 check("fa_in_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        #1 check("fa_arvalid1", arvalid, 1);
        check("fa_araddr", araddr, 32'h8000_0040);
        tick();
        #1 check("fa_arvalid2", arvalid, 1);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        #1 check("fa_drain_arvalid", arvalid, 0);
        check("fa_drain_rready", rready, 1);
        check("fa_drain_out_valid", out_valid, 0);
        tick();
        #1 check("fa_drain_rready2", rready, 1);
        rvalid = 1'b1; rdata = 32'hdead_beef;
        tick();
        rvalid = 1'b0; rdata = '0;
        #1 check("fa_out_valid", out_valid, 0);
        check("fa_rready_idle", rready, 0);
        check("fa_in_ready_idle", in_ready, 1);
        tick();
        #1 check("fa_out_valid_late", out_valid, 0);
        v = '{32'h8000_0100, 32'h0080_006f, 2'b00, 0, 0, 0, 32'h0080_006f, 1'b0};
        fetch_to_done(v, 1'b0);
        release_out();

        // Flush coincident with arready: straight to drain
        in_valid = 1'b1; in_pc = 32'h8000_0200;
        tick();
        in_valid = 1'b0; flush = 1'b1; arready = 1'b1;
        tick();
        flush = 1'b0; arready = 1'b0;
        #1 check("far_rready", rready, 1);
        rvalid = 1'b1; rdata = 32'h2222_2222;
        tick();
        rvalid = 1'b0;
        #1 check("far_out_valid", out_valid, 0);
        check("far_in_ready", in_ready, 1);

        // Flush coincident with rvalid in DATA: data dropped, IDLE next cycle
        in_valid = 1'b1; in_pc = 32'h8000_0300;
        tick();
        in_valid = 1'b0; arready = 1'b1;
        tick();
        arready = 1'b0; rvalid = 1'b1; rdata = 32'h1111_1111; flush = 1'b1;
        tick();
        rvalid = 1'b0; flush = 1'b0;
        #1 check("fd_out_valid", out_valid, 0);
        check("fd_rready", rready, 0);
        check("fd_in_ready", in_ready, 1);

        // Flush in DATA before rvalid: drain the late response
        in_valid = 1'b1; in_pc = 32'h8000_0400;
        tick();
        in_valid = 1'b0; arready = 1'b1;
        tick();
        arready = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        #1 check("fdd_rready", rready, 1);
        check("fdd_in_ready", in_ready, 0);
        rvalid = 1'b1; rdata = 32'h3333_3333;
        tick();
        rvalid = 1'b0;
        #1 check("fdd_out_valid", out_valid, 0);
        check("fdd_in_ready_idle", in_ready, 1);

        // Flush in DONE with a coincident handshake: handshake void
        v = '{32'h8000_0500, 32'h0000_0013, 2'b00, 0, 0, 0, 32'h0000_0013, 1'b0};
        fetch_to_done(v, 1'b0);
        out_ready = 1'b1; in_valid = 1'b1; in_pc = 32'h8000_0504; flush = 1'b1;
        #1 check("fdn_in_ready", in_ready, 0);
        tick();
        out_ready = 1'b0; in_valid = 1'b0; flush = 1'b0;
        #1 check("fdn_out_valid", out_valid, 0);
        check("fdn_arvalid", arvalid, 0);
        check("fdn_in_ready_idle", in_ready, 1);

        // Reset mid-transaction returns to IDLE immediately
        in_valid = 1'b1; in_pc = 32'h8000_0600;
        tick();
        in_valid = 1'b0;
        #1 check("mr_arvalid_before", arvalid, 1);
        rstn = 1'b0;
        #1 check("mr_arvalid", arvalid, 0);
        check("mr_araddr", araddr, 0);
        check("mr_in_ready", in_ready, 0);
        tick();
        rstn = 1'b1;
        tick();
        #1 check("mr_in_ready_after", in_ready, 1);
        check("mr_out_valid_after", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ysyx_23060203_ifu.md
Name: ysyx_23060203_ifu

Overview:
Instruction fetch unit that consumes the PC stream from the PC generator and fetches each instruction over an AXI4-Lite read channel (AR and R only). It hands {pc, inst, err} to the decoder with a valid/ready handshake. It keeps at most one bus transaction outstanding and discards in-flight fetches when a redirect flush arrives.

Parameters:
ADDR_W, 32, width of PC and araddr
DATA_W, 32, width of the instruction word and rdata

Ports:
clk  input  1  clock, rising edge
rstn  input  1  reset, asynchronous, active-low
in_valid  input  1  PC generator offers a PC
in_ready  output  1  IFU accepts the PC this cycle
in_pc  input  ADDR_W  PC to fetch
flush  input  1  redirect; kill the current fetch
araddr  output  ADDR_W  AXI read address
arvalid  output  1  AXI read address valid
arready  input  1  AXI read address ready
rdata  input  DATA_W  AXI read data
rresp  input  2  AXI read response
rvalid  input  1  AXI read data valid
rready  output  1  AXI read data ready
out_valid  output  1  fetched instruction valid toward the decoder
out_ready  input  1  decoder accepts
out_pc  output  ADDR_W  PC of the fetched instruction
out_inst  output  DATA_W  instruction word
out_err  output  1  bus error on this fetch

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous and active-low. While rstn=0:
  - state=IDLE.
  - pc_q, inst_q and err_q are 0.
  - arvalid=0, rready=0, out_valid=0.
  - in_ready=0.
- Reset asserted mid-transaction returns the block to IDLE immediately. The bus slave shares rstn.
- States: IDLE, ADDR, DATA, DONE, DRAIN. All outputs are decoded from registered state and regs:
  - in_ready = ~flush & (IDLE | (DONE & out_ready)).
  - arvalid = ADDR.
  - araddr = pc_q.
  - rready = DATA | DRAIN.
  - out_valid = DONE.
  - out_pc = pc_q, out_inst = inst_q, out_err = err_q.
- IDLE:
  - in_valid & in_ready: latch pc_q <= in_pc, go to ADDR.
  - Otherwise stay in IDLE.
- ADDR:
  - araddr stays stable and arvalid stays high until arready, per AXI. It is never withdrawn, even on flush.
  - arready & ~flush & ~flushed_q: go to DATA.
  - arready & (flush | flushed_q): go to DRAIN.
  - A flush while waiting sets flushed_q. flushed_q clears on leaving ADDR.
- DATA:
  - rvalid: latch inst_q <= rdata and err_q <= (rresp != 0), go to DONE.
  - flush & rvalid in the same cycle: response is discarded, go to IDLE.
  - flush & ~rvalid: go to DRAIN.
- DRAIN:
  - rready=1. On rvalid, discard the response and go to IDLE. out_valid is never raised.
- DONE:
  - out_valid=1 and the output fields are held stable until out_ready.
  - out_ready & in_valid & ~flush: latch the new PC, go to ADDR. Back-to-back fetch, no IDLE bubble.
  - out_ready otherwise: go to IDLE.
  - flush: go to IDLE. A handshake in the same cycle is void, since the decoder is flushed too.
- Latency: minimum 3 cycles from the in handshake to out_valid, with zero-wait arready and rvalid. Steady-state throughput is one instruction per 3 cycles.
- One outstanding transaction only. rdata and rresp are sampled only when rvalid & rready.
- flush in IDLE has no effect beyond blocking in_ready that cycle.

Optional Feature:
- Macro: YSYX_23060203_IFU_ALIGN_CHECK_EN.
- Defined:
  - In IDLE, an accepted PC with in_pc[1:0] != 0 skips the bus entirely and goes straight to DONE.
  - Fields in that case: err_q=1, inst_q=0, out_pc=the misaligned PC. arvalid never asserts for it.
- Undefined: no check. Address bits [1:0] pass to araddr unchanged and the slave decides.

Test Plan:
- Reset: hold rstn=0 with in_valid=1 -> arvalid=0, out_valid=0, in_ready=0. Release -> in_ready=1 next cycle.
- Zero-wait fetch: in_pc=0x80000000; slave returns rdata=0x00000413 with rresp=0 -> araddr=0x80000000. Three cycles after acceptance: out_valid=1, out_pc=0x80000000, out_inst=0x00000413, out_err=0.
- Backpressure: arready delayed 4 cycles, rvalid delayed 3 cycles, out_ready low for 5 cycles -> araddr and arvalid held constant until arready; outputs held constant. Back-to-back PC 0x80000004 is accepted in the same cycle as the out handshake.
- Flush in ADDR: flush pulse while arvalid=1 and arready=0 -> arvalid stays 1 until arready. The later rvalid (rdata=0xdeadbeef) is consumed with rready=1; out_valid never rises; next in_pc=0x80000100 fetches normally.
- Flush coincident with rvalid in DATA: data is dropped; state=IDLE next cycle; out_valid=0.
- Bus error: rresp=2'b10 -> out_err=1 with the correct out_pc. With the macro defined, in_pc=0x80000002 -> no AR transaction, out_valid=1, out_err=1, out_inst=0.
